// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the multicycle RISC-V control path.
// Contents: opcode constants, branch funct3 codes, alu_op encodings
// (shared with alu_control), datapath mux-select encodings and the
// control FSM state enum.
// Optional feature macro: MC_CTRL_TRAP_EN adds the TRAP state to the enum.

package riscv_pkg;

    // Opcodes (instr[6:0]) recognised by the control FSM
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Branch conditions (instr[14:12])
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // alu_op encodings understood by alu_control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LUI   = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Control FSM states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JAL,
        ST_LUI
`ifdef MC_CTRL_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping up-counter of retired instructions.
// Ports:
//   clk   - clock, counts on rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - add one to the count this cycle
//   count - current count, wraps modulo 2^WIDTH
// Parameter: WIDTH - counter width in bits.

module retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RISC-V core.
// Sequences the shared ALU, unified memory port and register file through
// fetch / decode / execute / memory / writeback and counts retired
// instructions.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   opcode, funct3, zero - instruction fields and ALU zero flag
//   mem_ready            - memory completes the current access this cycle
//   mem_read, mem_write, adr_src          - memory port control
//   ir_write, pc_write, reg_write         - state element write strobes
//   alu_op, alu_src_a, alu_src_b, result_src - datapath selects
//   trap                 - illegal instruction detected
//   instret              - retired instruction count (INSTRET_W bits)
// Optional feature macro: MC_CTRL_TRAP_EN. When defined, illegal opcodes
// and unsupported branch conditions park the FSM in TRAP until reset.
// When undefined, illegal opcodes behave as uncounted NOPs and unsupported
// branch conditions are treated as not taken.

module multicycle_control
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_op,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    state_t state;
    state_t next_state;
    logic   retire;
    logic   branch_f3_ok;

    assign branch_f3_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; mem_ready only matters in FETCH, MEM_READ, MEM_WRITE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      next_state = ST_FETCH;
            ST_FETCH:     next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = ST_MEM_ADR;
                    OP_RTYPE:          next_state = ST_EXEC_R;
                    OP_ITYPE:          next_state = ST_EXEC_I;
                    OP_BRANCH:         next_state = ST_BRANCH;
                    OP_JAL:            next_state = ST_JAL;
                    OP_LUI:            next_state = ST_LUI;
`ifdef MC_CTRL_TRAP_EN
                    default:           next_state = ST_TRAP;
`else
                    default:           next_state = ST_FETCH;
`endif
                endcase
            end
            ST_MEM_ADR:   next_state = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    next_state = ST_FETCH;
            ST_MEM_WRITE: next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC_R:    next_state = ST_ALU_WB;
            ST_EXEC_I:    next_state = ST_ALU_WB;
            ST_LUI:       next_state = ST_ALU_WB;
            ST_ALU_WB:    next_state = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
            ST_BRANCH:    next_state = branch_f3_ok ? ST_FETCH : ST_TRAP;
            ST_TRAP:      next_state = ST_TRAP;
`else
            ST_BRANCH:    next_state = ST_FETCH;
`endif
            ST_JAL:       next_state = ST_ALU_WB;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Output decode; FETCH strobes are the only outputs gated by mem_ready
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_OP_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALU_OUT;
        case (state)
            ST_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            ST_MEM_WB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_LUI: begin
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_LUI;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_SUB;
                // Unsupported conditions never redirect the PC
                if (funct3 == F3_BEQ) begin
                    pc_write = zero;
                end else if (funct3 == F3_BNE) begin
                    pc_write = !zero;
                end
            end
            ST_JAL: begin
                // PC takes the target computed in DECODE (ALUOut) while the
                // ALU forms old PC + 4 for the link write in ALU_WB
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_TRAP_EN
    assign trap = (state == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

    // An instruction retires when its final state hands back to FETCH;
    // the DECODE->FETCH NOP path is deliberately excluded
    assign retire = (next_state == ST_FETCH) &&
                    ((state == ST_MEM_WB) || (state == ST_MEM_WRITE) ||
                     (state == ST_ALU_WB) || (state == ST_BRANCH));

    retire_counter #(
        .WIDTH(INSTRET_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instret)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Walks instructions cycle by cycle and compares the packed control word
// {trap, mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
//  alu_op, alu_src_a, alu_src_b, result_src} against hand-computed values.
// Honours MC_CTRL_TRAP_EN for the illegal-instruction scenarios.

module tb_multicycle_control;

    localparam int INSTRET_W = 4;

    // Expected control words per state (trap is the MSB)
    localparam logic [14:0] S_IDLE       = 15'b0_0_0_0_0_0_0_00_00_00_00;
    localparam logic [14:0] S_FETCH      = 15'b0_1_0_0_1_1_0_00_00_10_10;
    localparam logic [14:0] S_FETCH_WAIT = 15'b0_1_0_0_0_0_0_00_00_10_10;
    localparam logic [14:0] S_DECODE     = 15'b0_0_0_0_0_0_0_00_01_01_00;
    localparam logic [14:0] S_MEM_ADR    = 15'b0_0_0_0_0_0_0_00_10_01_00;
    localparam logic [14:0] S_MEM_READ   = 15'b0_1_0_1_0_0_0_00_00_00_00;
    localparam logic [14:0] S_MEM_WB     = 15'b0_0_0_0_0_0_1_00_00_00_01;
    localparam logic [14:0] S_MEM_WRITE  = 15'b0_0_1_1_0_0_0_00_00_00_00;
    localparam logic [14:0] S_EXEC_R     = 15'b0_0_0_0_0_0_0_10_10_00_00;
    localparam logic [14:0] S_EXEC_I     = 15'b0_0_0_0_0_0_0_10_10_01_00;
    localparam logic [14:0] S_LUI        = 15'b0_0_0_0_0_0_0_11_00_01_00;
    localparam logic [14:0] S_ALU_WB     = 15'b0_0_0_0_0_0_1_00_00_00_00;
    localparam logic [14:0] S_BR_TAKEN   = 15'b0_0_0_0_0_1_0_01_10_00_00;
    localparam logic [14:0] S_BR_NOT     = 15'b0_0_0_0_0_0_0_01_10_00_00;
    localparam logic [14:0] S_JAL        = 15'b0_0_0_0_0_1_0_00_01_10_00;
    localparam logic [14:0] S_TRAP       = 15'b1_0_0_0_0_0_0_00_00_00_00;

    logic                 clk;
    logic                 rst_n;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 zero;
    logic                 mem_ready;
    logic                 mem_read;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_op;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic                 trap;
    logic [INSTRET_W-1:0] instret;
    logic [14:0]          ctrl;

    int                   vectors;
    int                   miscompares;
    logic [INSTRET_W-1:0] exp_instret;

    assign ctrl = {trap, mem_read, mem_write, adr_src, ir_write, pc_write,
                   reg_write, alu_op, alu_src_a, alu_src_b, result_src};

    multicycle_control #(
        .INSTRET_W(INSTRET_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .trap       (trap),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled around the falling edge
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        exp_instret = '0;
    endtask

    task automatic test_reset();
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if (ctrl !== S_IDLE) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, S_IDLE);
        end
        vectors++;
        if (instret !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
        end
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_r_type();
        logic [14:0] seq [5] = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB};
        opcode    = 7'b0110011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL r_type cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            next_cycle();
        end
        exp_instret = exp_instret + 1'b1;
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL r_type_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load_wait();
        logic [14:0] seq [8] = '{S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ,
                                 S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB};
        logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL load cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            next_cycle();
        end
        exp_instret = exp_instret + 1'b1;
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL load_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_store_fetch_wait();
        logic [14:0] seq [5] = '{S_FETCH_WAIT, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_WRITE};
        logic        rdy [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL store cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            next_cycle();
        end
        exp_instret = exp_instret + 1'b1;
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL store_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b000};
        logic        z   [3] = '{1'b1, 1'b1, 1'b0};
        logic [14:0] br  [3] = '{S_BR_TAKEN, S_BR_NOT, S_BR_NOT};
        logic [14:0] seq [3];
        opcode    = 7'b1100011;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            funct3 = f3[c];
            zero   = z[c];
            seq    = '{S_FETCH, S_DECODE, br[c]};
            for (int i = 0; i < 3; i++) begin
                #1;
                vectors++;
                if (ctrl !== seq[i]) begin
                    miscompares++;
                    $display("[TB] FAIL branch case %0d cycle %0d: got %b expected %b", c, i, ctrl, seq[i]);
                end
                next_cycle();
            end
            exp_instret = exp_instret + 1'b1;
            vectors++;
            if (instret !== exp_instret) begin
                miscompares++;
                $display("[TB] FAIL branch_instret case %0d: got %0d expected %0d", c, instret, exp_instret);
            end
        end
        zero   = 1'b0;
        funct3 = 3'b000;
    endtask

    task automatic test_jal_lui_itype();
        logic [6:0]  ops [3] = '{7'b1101111, 7'b0110111, 7'b0010011};
        logic [14:0] ex  [3] = '{S_JAL, S_LUI, S_EXEC_I};
        logic [14:0] seq [4];
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            opcode = ops[c];
            seq    = '{S_FETCH, S_DECODE, ex[c], S_ALU_WB};
            for (int i = 0; i < 4; i++) begin
                #1;
                vectors++;
                if (ctrl !== seq[i]) begin
                    miscompares++;
                    $display("[TB] FAIL jal_lui_i case %0d cycle %0d: got %b expected %b", c, i, ctrl, seq[i]);
                end
                next_cycle();
            end
            exp_instret = exp_instret + 1'b1;
            vectors++;
            if (instret !== exp_instret) begin
                miscompares++;
                $display("[TB] FAIL jal_lui_i_instret case %0d: got %0d expected %0d", c, instret, exp_instret);
            end
        end
    endtask

    task automatic test_instret_wrap();
        opcode    = 7'b1100011;
        funct3    = 3'b001;
        zero      = 1'b1;
        mem_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            next_cycle();
            next_cycle();
            next_cycle();
            exp_instret = exp_instret + 1'b1;
        end
        #1;
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL instret_wrap: got %0d expected %0d", instret, exp_instret);
        end
        zero   = 1'b0;
        funct3 = 3'b000;
    endtask

    task automatic test_reset_mid_write();
        logic [14:0] seq [5] = '{S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_WRITE, S_MEM_WRITE};
        logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL midreset_walk cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            if (i < 4) next_cycle();
        end
        rst_n = 1'b0;
        #1;
        exp_instret = '0;
        vectors++;
        if (ctrl !== S_IDLE) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctrl: got %b expected %b", ctrl, S_IDLE);
        end
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL midreset_instret: got %0d expected 0", instret);
        end
        next_cycle();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctrl !== S_IDLE) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle: got %b expected %b", ctrl, S_IDLE);
        end
        next_cycle();
        #1;
        vectors++;
        if (ctrl !== S_FETCH) begin
            miscompares++;
            $display("[TB] FAIL midreset_fetch: got %b expected %b", ctrl, S_FETCH);
        end
    endtask

    task automatic test_illegal_opcode();
        logic [14:0] seq [2] = '{S_FETCH, S_DECODE};
        opcode    = 7'b1111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL illegal_op cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            next_cycle();
        end
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctrl !== S_TRAP) begin
                miscompares++;
                $display("[TB] FAIL illegal_op_trap cycle %0d: got %b expected %b", i, ctrl, S_TRAP);
            end
            next_cycle();
        end
`else
        #1;
        vectors++;
        if (ctrl !== S_FETCH) begin
            miscompares++;
            $display("[TB] FAIL illegal_op_nop: got %b expected %b", ctrl, S_FETCH);
        end
`endif
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL illegal_op_instret: got %0d expected %0d", instret, exp_instret);
        end
`ifdef MC_CTRL_TRAP_EN
        do_reset();
`endif
    endtask

    task automatic test_illegal_branch();
        logic [14:0] seq [3] = '{S_FETCH, S_DECODE, S_BR_NOT};
        opcode    = 7'b1100011;
        funct3    = 3'b010;
        zero      = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctrl !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL illegal_br cycle %0d: got %b expected %b", i, ctrl, seq[i]);
            end
            next_cycle();
        end
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (ctrl !== S_TRAP) begin
                miscompares++;
                $display("[TB] FAIL illegal_br_trap cycle %0d: got %b expected %b", i, ctrl, S_TRAP);
            end
            next_cycle();
        end
`else
        exp_instret = exp_instret + 1'b1;
        #1;
        vectors++;
        if (ctrl !== S_FETCH) begin
            miscompares++;
            $display("[TB] FAIL illegal_br_next: got %b expected %b", ctrl, S_FETCH);
        end
`endif
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("[TB] FAIL illegal_br_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_instret = '0;
        rst_n       = 1'b0;
        opcode      = 7'b0;
        funct3      = 3'b0;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_fetch_wait();
        test_branch();
        test_jal_lui_itype();
        test_instret_wrap();
        test_reset_mid_write();
        test_illegal_opcode();
        test_illegal_branch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V core. It sequences one shared ALU, one unified memory port and the register file through fetch, decode, execute, memory and writeback. Per state it drives `alu_op` to `alu_control` and the datapath mux selects and write strobes. It also keeps a retired-instruction counter.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`, used for branch condition.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `adr_src` output 1: memory address; 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load the instruction register and old-PC register.
- `pc_write` output 1: load PC from the result mux.
- `reg_write` output 1: register file write.
- `alu_op` output 2: to `alu_control`; 00 ADD, 01 SUB, 10 funct decode, 11 LUI pass.
- `alu_src_a` output 2: 00 PC, 01 old PC, 10 rs1 register.
- `alu_src_b` output 2: 00 rs2 register, 01 immediate, 10 constant 4.
- `result_src` output 2: 00 ALUOut, 01 data register, 10 ALU result (direct).
- `trap` output 1: illegal instruction detected (see Configuration).
- `instret` output `INSTRET_W`: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI, TRAP.
- Any output not listed for a state is 0.
- IDLE: all outputs 0; always goes to FETCH next.
- FETCH: `mem_read`=1, `adr_src`=0, a=PC, b=4, op=00, `result_src`=10. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
- DECODE: a=old PC, b=imm, op=00, so the branch/JAL target lands in ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → illegal
- MEM_ADR: a=rs1, b=imm, op=00. Go to MEM_READ for load opcode, MEM_WRITE for store opcode.
- MEM_READ: `mem_read`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: `result_src`=01, `reg_write`=1, go to FETCH.
- MEM_WRITE: `mem_write`=1, `adr_src`=1. Wait for `mem_ready`, then go to FETCH.
- EXEC_R: a=rs1, b=rs2, op=10, go to ALU_WB.
- EXEC_I: a=rs1, b=imm, op=10, go to ALU_WB.
- LUI: b=imm, op=11, go to ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1, go to FETCH.
- BRANCH: a=rs1, b=rs2, op=01, `result_src`=00.
  - `pc_write` = `zero` for funct3 000 (BEQ); `pc_write` = !`zero` for funct3 001 (BNE).
  - Other funct3 values are illegal.
  - Go to FETCH.
- JAL: a=old PC, b=4, op=00, `result_src`=00, `pc_write`=1 (target taken from ALUOut), go to ALU_WB. ALU_WB then writes old PC+4 to rd.
- Memory handshake:
  - `mem_read`/`mem_write` and `adr_src` stay constant from state entry until `mem_ready` is sampled high.
  - `mem_ready` is ignored in all other states.
  - `ir_write`/`pc_write` in FETCH are gated by `mem_ready`.
- `instret` increments by 1 on the cycle the FSM moves to FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH. It wraps modulo 2^`INSTRET_W`. Illegal instructions do not count.

## Timing
- Outputs are Moore decodes of the registered state. The exception is the `mem_ready`-gated strobes, which are combinational on `mem_ready`.
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1): R/I/LUI/JAL 4, LW 5, SW 4, branch 3. Each wait cycle adds 1.
- Reset, including mid-instruction: state IDLE, `instret`=0, `trap`=0, every output 0 while `rst_n`=0. The first FETCH is in the second cycle after release.

## Configuration
- `MC_CTRL_TRAP_EN` defined:
  - An illegal opcode, or BRANCH with funct3 ∉ {000,001}, goes to TRAP.
  - In TRAP, `trap`=1, all strobes are 0 and the FSM stays until reset.
- `MC_CTRL_TRAP_EN` undefined:
  - An illegal opcode goes from DECODE straight to FETCH as a NOP, not counted.
  - An illegal branch funct3 is treated as not taken, and the instruction is counted.
  - `trap` is tied to 0 and the TRAP state is not built.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants
  - `alu_op` encodings (shared with `alu_control`)
  - `alu_src_a`/`alu_src_b`/`result_src` encodings
  - the state enum
- One sub-module: `retire_counter`, a parameterised width counter with `clk`, `rst_n` and `inc` inputs.

## Test plan
- Reset release with `mem_ready`=1, opcode 0110011: states IDLE, FETCH, DECODE, EXEC_R, ALU_WB. `reg_write`=1 in cycle 5; `instret`=1.
- LW with `mem_ready` low for 3 cycles in MEM_READ: `mem_read`=1 and `adr_src`=1 held for 4 cycles; MEM_WB has `result_src`=01. Total 8 cycles.
- BEQ, `zero`=1 → `pc_write`=1 in BRANCH. BNE, `zero`=1 → `pc_write`=0. Both take 3 cycles and increment `instret`.
- JAL: `pc_write`=1 in JAL with `result_src`=00, then `reg_write`=1 in ALU_WB. LUI drives `alu_op`=11, b=01.
- Opcode 1111111:
  - with `MC_CTRL_TRAP_EN`: `trap`=1, stuck, `instret` unchanged.
  - without `MC_CTRL_TRAP_EN`: FETCH follows DECODE, `trap`=0.
- `rst_n` pulsed low during MEM_WRITE wait: `mem_write` drops to 0 immediately, `instret`=0. Then IDLE, then FETCH.
